// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
// Multiply/divide unit with HI/LO registers for the EX stage of a five-stage
// MIPS pipeline. Multiplies complete after a fixed MUL_LAT cycles; divides use
// a radix-2 restoring divider (one quotient bit per cycle) followed by a sign
// fix-up cycle. MTHI/MTLO write HI/LO directly in the accepting cycle.
//
// Optional build macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate the product into {hi,lo} at the writing edge. Without the macro
// those opcodes behave as no-ops.
//
// Parameters:
//   WIDTH   - operand and HI/LO width (>=4, even)
//   MUL_LAT - multiply latency in cycles (>=1)
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears all state
//   start - request; op/a/b sampled on the same edge (ignored while busy)
//   op    - operation select (MULT/MULTU/DIV/DIVU/MTHI/MTLO [+MADD family])
//   a     - rs operand (dividend / multiplicand / MT source)
//   b     - rt operand (divisor / multiplier)
//   flush - abort the in-flight op, or drop a request presented in IDLE
//   busy  - operation in progress (state != IDLE)
//   done  - one-cycle pulse when HI/LO are written by a mul/div
//   hi    - HI register
//   lo    - LO register
// -----------------------------------------------------------------------------
module mdu_iterative #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b1000;
  localparam logic [3:0] OP_MADDU = 4'b1001;
  localparam logic [3:0] OP_MSUB  = 4'b1010;
  localparam logic [3:0] OP_MSUBU = 4'b1011;
`endif

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;

  // Counter must hold both MUL_LAT-1 and WIDTH-1.
  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] MUL_CNT_INIT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mduStateT;

  mduStateT         state;
  logic [CW-1:0]    count;
  // regA: multiplicand, or dividend shifting out while quotient shifts in.
  // regB: multiplier, or divisor magnitude.
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] remR;
  logic             mulSigned;
  logic [1:0]       accMode;
  logic             negQ;
  logic             negR;
  logic             divZero;

  logic [2*WIDTH-1:0] mulA;
  logic [2*WIDTH-1:0] mulB;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mulResult;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   nextRem;
  logic [WIDTH-1:0]   nextQuo;
  logic [WIDTH-1:0]   quoFinal;
  logic [WIDTH-1:0]   remFinal;
  logic               divSigned;
  logic [WIDTH-1:0]   divA;
  logic [WIDTH-1:0]   divB;

  // Busy flag decoded from the state register.
  always_comb begin
    busy = (state != IDLE);
  end

  // Full-width product of the latched operands and the value written to {hi,lo}.
  always_comb begin
    if (mulSigned) begin
      mulA = {{WIDTH{regA[WIDTH-1]}}, regA};
      mulB = {{WIDTH{regB[WIDTH-1]}}, regB};
    end else begin
      mulA = {{WIDTH{1'b0}}, regA};
      mulB = {{WIDTH{1'b0}}, regB};
    end
    // Truncating the 2W x 2W product to 2W bits gives the exact signed or
    // unsigned W x W product, since the operands are extended accordingly.
    product = mulA * mulB;
    case (accMode)
      ACC_ADD: mulResult = {hi, lo} + product;
      ACC_SUB: mulResult = {hi, lo} - product;
      default: mulResult = product;
    endcase
  end

  // One restoring division step: shift in the next dividend bit and subtract.
  always_comb begin
    divShift = {remR, regA[WIDTH-1]};
    divGe    = (divShift >= {1'b0, regB});
    // When the subtraction succeeds the difference is below the divisor, so
    // the low W bits alone hold it exactly.
    if (divGe) begin
      nextRem = divShift[WIDTH-1:0] - regB;
    end else begin
      nextRem = divShift[WIDTH-1:0];
    end
    nextQuo = {regA[WIDTH-2:0], divGe};
  end

  // Sign correction of the magnitude quotient/remainder.
  always_comb begin
    // Divide by zero: the restoring loop already leaves |a| in the remainder,
    // so only the quotient needs forcing to all ones.
    if (divZero) begin
      quoFinal = {WIDTH{1'b1}};
    end else if (negQ) begin
      quoFinal = -regA;
    end else begin
      quoFinal = regA;
    end
    if (negR) begin
      remFinal = -remR;
    end else begin
      remFinal = remR;
    end
  end

  // Operand magnitudes for a divide request.
  always_comb begin
    divSigned = (op == OP_DIV);
    if (divSigned && a[WIDTH-1]) begin
      divA = -a;
    end else begin
      divA = a;
    end
    if (divSigned && b[WIDTH-1]) begin
      divB = -b;
    end else begin
      divB = b;
    end
  end

  // Control FSM, operand/result registers and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= {CW{1'b0}};
      regA      <= {WIDTH{1'b0}};
      regB      <= {WIDTH{1'b0}};
      remR      <= {WIDTH{1'b0}};
      mulSigned <= 1'b0;
      accMode   <= ACC_NONE;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      divZero   <= 1'b0;
      done      <= 1'b0;
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Abort wins over any request or pending write-back.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (op)
                OP_MULT, OP_MULTU: begin
                  regA      <= a;
                  regB      <= b;
                  mulSigned <= ~op[0];
                  accMode   <= ACC_NONE;
                  count     <= MUL_CNT_INIT;
                  state     <= MUL;
                end
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU: begin
                  regA      <= a;
                  regB      <= b;
                  mulSigned <= ~op[0];
                  accMode   <= ACC_ADD;
                  count     <= MUL_CNT_INIT;
                  state     <= MUL;
                end
                OP_MSUB, OP_MSUBU: begin
                  regA      <= a;
                  regB      <= b;
                  mulSigned <= ~op[0];
                  accMode   <= ACC_SUB;
                  count     <= MUL_CNT_INIT;
                  state     <= MUL;
                end
`endif
                OP_DIV, OP_DIVU: begin
                  regA    <= divA;
                  regB    <= divB;
                  remR    <= {WIDTH{1'b0}};
                  negQ    <= divSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                  negR    <= divSigned & a[WIDTH-1];
                  divZero <= (b == {WIDTH{1'b0}});
                  count   <= DIV_CNT_INIT;
                  state   <= DIV;
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: state <= IDLE;
              endcase
            end else begin
              state <= IDLE;
            end
          end
          MUL: begin
            if (count == {CW{1'b0}}) begin
              {hi, lo} <= mulResult;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              count <= count - CW'(1);
            end
          end
          DIV: begin
            regA <= nextQuo;
            remR <= nextRem;
            if (count == {CW{1'b0}}) begin
              state <= FIX;
            end else begin
              count <= count - CW'(1);
            end
          end
          FIX: begin
            lo    <= quoFinal;
            hi    <= remFinal;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative
// Scoreboard bench for mdu_iterative (WIDTH=32, MUL_LAT=5). Each accepted
// mul/div pushes its expected {hi,lo} and completion cycle; a monitor pops on
// every done pulse. Expected values come from a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_mdu_iterative;

  localparam int W = 32;
  localparam int L = 5;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MADD  = 4'b1000;
  localparam logic [3:0] OP_MADDU = 4'b1001;
  localparam logic [3:0] OP_MSUB  = 4'b1010;
  localparam logic [3:0] OP_MSUBU = 4'b1011;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op    = 4'b0000;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } expT;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    bit           pulses;
  } resT;

  expT sb[$];
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  mdu_iterative #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    expT e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_cycle", cyc, e.due);
      end
    end
  end

  // Reference model: architectural effect of one operation on {hi,lo}.
  function automatic resT refModel(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] h, input logic [W-1:0] l);
    resT r;
    logic [63:0] p;
    int sx;
    int sy;
    r.hi = h; r.lo = l; r.lat = 0; r.pulses = 1'b0;
    sx = x; sy = y;
    case (o)
      OP_MULT:  begin p = longint'(sx) * longint'(sy); {r.hi, r.lo} = p; r.lat = L; r.pulses = 1'b1; end
      OP_MULTU: begin p = {32'h0, x} * {32'h0, y};     {r.hi, r.lo} = p; r.lat = L; r.pulses = 1'b1; end
      OP_DIV: begin
        if (y == 32'h0) begin r.hi = x; r.lo = 32'hFFFFFFFF; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin r.lo = x; r.hi = 32'h0; end
        else begin r.lo = sx / sy; r.hi = sx % sy; end
        r.lat = W + 1; r.pulses = 1'b1;
      end
      OP_DIVU: begin
        if (y == 32'h0) begin r.hi = x; r.lo = 32'hFFFFFFFF; end
        else begin r.lo = x / y; r.hi = x % y; end
        r.lat = W + 1; r.pulses = 1'b1;
      end
      OP_MTHI: r.hi = x;
      OP_MTLO: r.lo = x;
`ifdef MDU_MADD_EN
      OP_MADD:  begin p = longint'(sx) * longint'(sy); {r.hi, r.lo} = {h, l} + p; r.lat = L; r.pulses = 1'b1; end
      OP_MADDU: begin p = {32'h0, x} * {32'h0, y};     {r.hi, r.lo} = {h, l} + p; r.lat = L; r.pulses = 1'b1; end
      OP_MSUB:  begin p = longint'(sx) * longint'(sy); {r.hi, r.lo} = {h, l} - p; r.lat = L; r.pulses = 1'b1; end
      OP_MSUBU: begin p = {32'h0, x} * {32'h0, y};     {r.hi, r.lo} = {h, l} - p; r.lat = L; r.pulses = 1'b1; end
`endif
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] randVal();
    case ($urandom_range(0, 5))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int e0);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic runOp(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    resT r;
    expT e;
    int  e0;
    int  n;
    r = refModel(o, x, y, modelHi, modelLo);
    issue(o, x, y, e0);
    if (r.pulses) begin
      e.hi = r.hi; e.lo = r.lo; e.due = e0 + r.lat;
      sb.push_back(e);
      check({tag, "_busy_rise"}, busy, 1);
      n = 0;
      while (n < 200) begin
        @(negedge clk);
        if (!busy) break;
        n++;
      end
      check({tag, "_busy_cycles"}, n, r.lat);
    end else begin
      @(negedge clk);
      check({tag, "_busy_low"}, busy, 0);
    end
    modelHi = r.hi;
    modelLo = r.lo;
    check({tag, "_hi"}, hi, modelHi);
    check({tag, "_lo"}, lo, modelLo);
  endtask

  initial begin
    int e0;
    int dn;
    logic [3:0] ro;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    runOp(OP_MULT,  32'hFFFFFFFE, 32'h3, "mult");
    runOp(OP_MULTU, 32'hFFFFFFFE, 32'h3, "multu");
    runOp(OP_DIVU,  32'd100, 32'd7, "divu");
    runOp(OP_DIV,   32'hFFFFFFF9, 32'd2, "div_neg");
    runOp(OP_DIV,   32'd5, 32'd0, "div_zero");
    runOp(OP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_ovf");
    runOp(OP_MTHI,  32'h12345678, 32'h0, "mthi");

    // Flush on busy cycle 10 of a DIVU; a MULT start while busy is ignored
    issue(OP_DIVU, 32'd9, 32'd2, e0);
    dn = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (k == 3) begin
        start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (k == 10) flush = 1'b1;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("flush_quiet", dn, 0);
    check("flush_hi", hi, modelHi);
    check("flush_lo", lo, modelLo);

    // flush with start in IDLE drops the request
    @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_lo", lo, modelLo);
    check("idle_flush_busy", busy, 0);

    // flush coinciding with the writing edge of a MULT
    issue(OP_MULT, 32'd123, 32'd456, e0);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == L) flush = 1'b1;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("final_flush_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("final_flush_hi", hi, modelHi);
    check("final_flush_lo", lo, modelLo);

    // Accumulate sequence (no-op when the option is compiled out)
    runOp(OP_MTHI,  32'h0, 32'h0, "acc_mthi");
    runOp(OP_MTLO,  32'hFFFFFFFF, 32'h0, "acc_mtlo");
    runOp(OP_MADDU, 32'd1, 32'd1, "maddu");
    runOp(OP_MSUB,  32'd1, 32'd2, "msub");

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       ro = OP_MULT;
        1:       ro = OP_MULTU;
        2:       ro = OP_DIV;
        3:       ro = OP_DIVU;
        4:       ro = OP_MTHI;
        5:       ro = OP_MTLO;
        6:       ro = 4'(4'b1000 + 4'($urandom_range(0, 3)));
        default: ro = 4'($urandom_range(0, 15));
      endcase
      runOp(ro, randVal(), randVal(), "rand");
    end

    // Asynchronous reset in the middle of a MULT
    runOp(OP_MULT, 32'h00010000, 32'h00030000, "pre_rst");
    issue(OP_MULT, 32'h55, 32'h77, e0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    modelHi = '0;
    modelLo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (L + 3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_hi", hi, modelHi);
    check("post_rst_lo", lo, modelLo);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the five-stage MIPS pipeline; sits in EX alongside the ALU.
- Provides MULT/MULTU/DIV/DIVU/MTHI/MTLO with configurable multiply latency and a radix-2 restoring divider.
- The busy output feeds the hazard detector, which stalls dependent MFHI/MFLO and any further MDU ops while busy is high.
- The flush input lets the pipeline abort an in-flight op on reset or exception.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4, even).
- MUL_LAT, 5, multiply latency in cycles (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; op/a/b are sampled on the same edge.
- op  input  4  0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO, 1000 MADD, 1001 MADDU, 1010 MSUB, 1011 MSUBU; all others are no-op.
- a  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort the in-flight op.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- One clock domain; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counters=0. Reset asserted mid-operation aborts immediately; no done pulse.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start && MULT/MULTU: latch operands, go to MUL, count=MUL_LAT-1.
  - start && DIV/DIVU: latch |a|, |b| (signed) or raw values (unsigned) and the sign flags, go to DIV, count=WIDTH-1.
  - start && MTHI/MTLO: hi (or lo) <= a at that edge; stay IDLE; busy stays 0; no done.
- busy is combinational (state!=IDLE) and rises in the cycle after the start edge.
- MUL:
  - The full 2*WIDTH product is computed from the latched operands (signed or unsigned).
  - Count decrements each cycle; at count==0 the edge writes {hi,lo}, sets done=1 for one cycle and returns to IDLE.
  - Total: start edge E0, results visible after edge E0+MUL_LAT.
  - MUL_LAT=1: written at E0+1.
- DIV:
  - One restoring quotient bit per cycle for WIDTH cycles, then FIX.
- FIX:
  - Applies signs: quotient is negative iff the signs of a and b differ; remainder takes the sign of a.
  - Writes lo=quotient, hi=remainder, pulses done, returns to IDLE.
  - Results after edge E0+WIDTH+1.
- Divide by zero: no trap; completes with normal latency; hi=a (original dividend), lo=all ones.
- Signed overflow (a=most-negative, b=-1): lo=most-negative, hi=0.
- start while busy: ignored entirely, including MTHI/MTLO. The hazard unit must hold the request.
- flush while busy: state returns to IDLE at the next edge; hi/lo keep their pre-op values; no done.
- flush && start in IDLE: flush wins; the request is dropped.
- flush && the final (writing) edge in the same cycle: flush wins; no write.
- done is never asserted in the same cycle as start acceptance.
- Unknown op with start: no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 1000/1001 (MADD/MADDU) give {hi,lo} <= {hi,lo} + product.
  - op 1010/1011 (MSUB/MSUBU) give {hi,lo} <= {hi,lo} - product.
  - Signedness follows the op; arithmetic is modulo 2^(2*WIDTH).
  - Same MUL_LAT latency and done pulse.
  - {hi,lo} is sampled at the writing edge, not at start.
- Undefined: these four opcodes are treated as unknown, i.e. no-op.

Test Plan (WIDTH=32, MUL_LAT=5):
- MULT a=0xFFFFFFFE, b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done high exactly 1 cycle. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIVU a=100, b=7 -> after 33 cycles lo=14, hi=2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 -> hi=5, lo=0xFFFFFFFF after 33 cycles. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never rises. Then DIVU 9/2 started, flush pulsed on busy cycle 10 -> busy low after one edge, hi=0x12345678 unchanged, no done. A MULT start issued while busy is ignored.
- Reset asserted asynchronously mid-MUL (between edges) -> busy, done, hi, lo read 0 immediately, before any clock edge.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> hi=1, lo=0. Then MSUB a=1, b=2 -> hi=0, lo=0xFFFFFFFE. Without the macro the same sequence leaves hi/lo unchanged and busy low.
